hx711_avg_filter: RTL and testbench

HX711_AVG_FILTER -- requirements
Module: hx711_avg_filter

---
 rtl/hx711_pkg.sv | 19 +
 rtl/hx711_stability_det.sv | 72 +++++++
 rtl/hx711_avg_filter.sv | 119 +++++++++++
 tb/tb_hx711_avg_filter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hx711_pkg.sv
// ----------------------------------------------------------------------------
// hx711_pkg
// Shared types for the HX711 signal path (driver, averaging filter, top).
//   SAMPLE_W      : width of one raw HX711 conversion (two's complement)
//   sample_t      : signed raw sample / averaged reading
//   fill_state_t  : state of the moving-average window
// ----------------------------------------------------------------------------
package hx711_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_FULL    = 1'b1
    } fill_state_t;

endpackage

// File: rtl/hx711_stability_det.sv
// ----------------------------------------------------------------------------
// hx711_stability_det
// Decides whether successive averaged readings have settled.
//   clk, rst_n  : clock, asynchronous active-low reset
//   avg         : averaged reading that is about to be presented downstream
//   avg_valid   : one-cycle tick qualifying avg
//   clear       : synchronous flush (forget the reference and the count)
//   stable      : high while STABLE_COUNT consecutive deltas were in threshold
// The first qualified average after a flush only becomes the reference.
// The parent feeds this block the not-yet-registered average, so stable
// changes on the same edge that updates the registered avg_out/avg_valid.
// ----------------------------------------------------------------------------
module hx711_stability_det
    import hx711_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] STABLE_THRESH = 24'd100,
    parameter int unsigned         STABLE_COUNT  = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t avg,
    input  logic    avg_valid,
    input  logic    clear,
    output logic    stable
);

    localparam int              CNT_W   = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);

    logic             r_have_ref;
    sample_t          r_prev_avg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    logic [SAMPLE_W:0] w_delta;
    logic [SAMPLE_W:0] w_abs;
    logic              w_within;
    logic [CNT_W-1:0]  w_cnt_next;

    // 25-bit difference cannot overflow for any pair of 24-bit readings.
    assign w_delta    = {avg[SAMPLE_W-1], avg} - {r_prev_avg[SAMPLE_W-1], r_prev_avg};
    assign w_abs      = w_delta[SAMPLE_W] ? (~w_delta + 1'b1) : w_delta;
    assign w_within   = (w_abs <= {1'b0, STABLE_THRESH});
    assign w_cnt_next = !w_within          ? '0    :
                        (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_have_ref <= 1'b0;
            r_prev_avg <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
        end else if (clear) begin
            r_have_ref <= 1'b0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
        end else if (avg_valid) begin
            r_prev_avg <= avg;
            if (!r_have_ref) begin
                r_have_ref <= 1'b1;
                r_cnt      <= '0;
                r_stable   <= 1'b0;
            end else begin
                r_cnt      <= w_cnt_next;
                r_stable   <= (w_cnt_next == CNT_MAX);
            end
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/hx711_avg_filter.sv
// ----------------------------------------------------------------------------
// hx711_avg_filter
// Moving-average filter over the last 2^DEPTH_LOG2 HX711 samples.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sample_in    : signed raw sample from the HX711 driver
//   sample_valid : one-cycle tick qualifying sample_in
//   clear        : synchronous flush (tare / re-zero); wins over sample_valid
//   avg_out      : registered signed average (held across clear)
//   avg_valid    : one-cycle tick, 1 cycle after each sample accepted in FULL
//   primed       : window holds a full set of samples
//   stable       : averaged reading has settled (see hx711_stability_det)
// ----------------------------------------------------------------------------
module hx711_avg_filter
    import hx711_pkg::*;
#(
    parameter int unsigned         DEPTH_LOG2    = 3,
    parameter logic [SAMPLE_W-1:0] STABLE_THRESH = 24'd100,
    parameter int unsigned         STABLE_COUNT  = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t sample_in,
    input  logic    sample_valid,
    input  logic    clear,
    output sample_t avg_out,
    output logic    avg_valid,
    output logic    primed,
    output logic    stable
);

    localparam int                  WIN       = 1 << DEPTH_LOG2;
    localparam int                  SUM_W     = SAMPLE_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FILL_LAST = (DEPTH_LOG2 + 1)'(WIN - 1);

    fill_state_t                r_state;
    sample_t                    r_buf [WIN];
    logic [DEPTH_LOG2-1:0]      r_ptr;
    logic [DEPTH_LOG2:0]        r_fill;
    logic signed [SUM_W-1:0]    r_sum;
    sample_t                    r_avg;
    logic                       r_avg_valid;
    logic                       r_primed;

    logic                       w_accept;
    logic                       w_fills_now;
    logic                       w_fire;
    sample_t                    w_evicted;
    logic signed [SUM_W-1:0]    w_sum_next;
    sample_t                    w_avg_next;

    assign w_accept    = sample_valid && !clear;
    assign w_fills_now = (r_state == ST_FILLING) && (r_fill == FILL_LAST);
    assign w_fire      = w_accept && ((r_state == ST_FULL) || w_fills_now);

    // Slot at r_ptr holds the oldest sample only once the window is full.
    assign w_evicted  = (r_state == ST_FULL) ? r_buf[r_ptr] : '0;
    assign w_sum_next = r_sum + SUM_W'(sample_in) - SUM_W'(w_evicted);
    // Dropping the low bits of a two's-complement sum is a floor division.
    assign w_avg_next = w_sum_next[SUM_W-1:DEPTH_LOG2];

    // Buffer is not reset: its slots are never read until overwritten.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILLING;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_primed    <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_FILLING;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_avg_valid <= 1'b0;
            r_primed    <= 1'b0;
        end else begin
            r_avg_valid <= w_fire;
            if (w_fire) begin
                r_avg <= w_avg_next;
            end
            if (w_accept) begin
                r_sum <= w_sum_next;
                r_ptr <= r_ptr + 1'b1;
                if (r_state == ST_FILLING) begin
                    r_fill <= r_fill + 1'b1;
                    if (w_fills_now) begin
                        r_state  <= ST_FULL;
                        r_primed <= 1'b1;
                    end
                end
            end
        end
    end

    hx711_stability_det #(
        .STABLE_THRESH (STABLE_THRESH),
        .STABLE_COUNT  (STABLE_COUNT)
    ) u_stab (
        .clk       (clk),
        .rst_n     (rst_n),
        .avg       (w_avg_next),
        .avg_valid (w_fire),
        .clear     (clear),
        .stable    (stable)
    );

    assign avg_out   = r_avg;
    assign avg_valid = r_avg_valid;
    assign primed    = r_primed;

endmodule

// File: tb/tb_hx711_avg_filter.sv
module tb_hx711_avg_filter;

    localparam int  WIN    = 8;
    localparam int  THRESH = 100;
    localparam int  SCOUNT = 4;

    logic               clk;
    logic               rst_n;
    logic signed [23:0] sample_in;
    logic               sample_valid;
    logic               clear;
    logic signed [23:0] avg_out;
    logic               avg_valid;
    logic               primed;
    logic               stable;

    int tests = 0;
    int fails = 0;

    // reference model state: the window is just the last WIN accepted samples
    longint win_q[$];
    longint exp_avg;
    longint prev_avg;
    bit     exp_valid, exp_primed, exp_stable, have_ref;
    int     stab_cnt;

    typedef struct {
        bit     v;
        longint s;
        bit     c;
        bit     e_valid;
        longint e_avg;
        bit     e_primed;
        bit     e_stable;
    } vec_t;
    vec_t tbl[11];

    hx711_avg_filter #(
        .DEPTH_LOG2    (3),
        .STABLE_THRESH (24'd100),
        .STABLE_COUNT  (SCOUNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .primed       (primed),
        .stable       (stable)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if (x < 0 && q * d != x) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        exp_avg    = 0;
        prev_avg   = 0;
        exp_valid  = 0;
        exp_primed = 0;
        exp_stable = 0;
        have_ref   = 0;
        stab_cnt   = 0;
    endtask

    task automatic model_apply(input bit v, input longint s, input bit c);
        longint sum, d;
        exp_valid = 0;
        if (c) begin
            win_q.delete();
            have_ref   = 0;
            stab_cnt   = 0;
            exp_stable = 0;
        end else if (v) begin
            win_q.push_back(s);
            if (win_q.size() > WIN) void'(win_q.pop_front());
            if (win_q.size() == WIN) begin
                sum = 0;
                foreach (win_q[i]) sum += win_q[i];
                exp_avg   = floor_div(sum, WIN);
                exp_valid = 1;
                if (!have_ref) begin
                    have_ref   = 1;
                    stab_cnt   = 0;
                    exp_stable = 0;
                end else begin
                    d = exp_avg - prev_avg;
                    if (d < 0) d = -d;
                    if (d <= THRESH) stab_cnt = (stab_cnt < SCOUNT) ? stab_cnt + 1 : SCOUNT;
                    else             stab_cnt = 0;
                    exp_stable = (stab_cnt == SCOUNT);
                end
                prev_avg = exp_avg;
            end
        end
        exp_primed = (win_q.size() == WIN);
    endtask

    // driver: called at a negedge, spends exactly one clock cycle
    task automatic step(input bit v, input longint s, input bit c);
        sample_valid = v;
        sample_in    = s[23:0];
        clear        = c;
        @(posedge clk);
        #1;
        model_apply(v, s, c);
        chk("avg_valid", avg_valid, exp_valid);
        chk("primed",    primed,    exp_primed);
        chk("stable",    stable,    exp_stable);
        chk("avg_out",   avg_out,   exp_avg);
        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic fill(input int n, input longint s);
        for (int i = 0; i < n; i++) step(1'b1, s, 1'b0);
    endtask

    initial begin
        longint s;
        bit v, c;

        // reset block
        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_avg_out",   avg_out,   0);
        chk("reset_avg_valid", avg_valid, 0);
        chk("reset_primed",    primed,    0);
        chk("reset_stable",    stable,    0);
        rst_n = 1'b1;
        @(negedge clk);

        // priming and step: table-driven with hand-computed expectations
        for (int i = 0; i < 7; i++) tbl[i] = '{1, 1000, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1000, 0, 1, 1000, 1, 0};
        tbl[8]  = '{0, 0,    0, 0, 1000, 1, 0};
        tbl[9]  = '{1, 8000, 0, 1, 1875, 1, 0};
        tbl[10] = '{0, 0,    0, 0, 1875, 1, 0};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].s, tbl[i].c);
            chk("tbl_avg_valid", avg_valid, tbl[i].e_valid);
            chk("tbl_avg_out",   avg_out,   tbl[i].e_avg);
            chk("tbl_primed",    primed,    tbl[i].e_primed);
            chk("tbl_stable",    stable,    tbl[i].e_stable);
        end

        // negative rounding and extremes
        step(1'b0, 0, 1'b1);
        chk("clear_holds_avg", avg_out, 1875);
        fill(7, 0);
        step(1'b1, -1, 1'b0);
        chk("neg_round", avg_out, -1);
        step(1'b0, 0, 1'b1);
        fill(8, -8388608);
        chk("min_avg", avg_out, -8388608);
        step(1'b0, 0, 1'b1);
        fill(8, 8388607);
        chk("max_avg", avg_out, 8388607);
        step(1'b1, -8388608, 1'b0);
        chk("mix_avg", avg_out, floor_div(7 * 8388607 - 8388608, 8));

        // stability: back-to-back 500s, then a violating step
        step(1'b0, 0, 1'b1);
        fill(11, 500);
        chk("stable_before_12", stable, 0);
        step(1'b1, 500, 1'b0);
        chk("stable_at_12", stable, 1);
        step(1'b1, 1500, 1'b0);
        chk("step_avg", avg_out, 625);
        chk("stable_drop", stable, 0);
        chk("step_valid", avg_valid, 1);

        // clear together with the 5th sample of a refill while primed
        step(1'b0, 0, 1'b1);
        chk("clear_primed", primed, 0);
        fill(4, 200);
        step(1'b1, 200, 1'b1);
        chk("clear5_valid", avg_valid, 0);
        chk("clear5_primed", primed, 0);
        fill(7, 300);
        chk("refill_no_valid", avg_valid, 0);
        step(1'b1, 300, 1'b0);
        chk("refill_valid", avg_valid, 1);
        chk("refill_avg", avg_out, 300);

        // asynchronous reset while FULL
        fill(3, 4000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_avg_out",   avg_out,   0);
        chk("arst_avg_valid", avg_valid, 0);
        chk("arst_primed",    primed,    0);
        chk("arst_stable",    stable,    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill(7, 50);
        chk("arst_refill_none", avg_valid, 0);
        step(1'b1, 50, 1'b0);
        chk("arst_refill_valid", avg_valid, 1);

        // randomized stimulus against the model
        for (int i = 0; i < 500; i++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) != 0)
                s = 12345 + longint'($urandom_range(0, 80)) - 40;
            else
                s = longint'($signed(24'($urandom)));
            step(v, s, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
